// File: rtl/kt_pkg.sv
// Shared constants for the KitchenTimer countdown core.
// State encodings, digit width and the default mm:ss modulus.
package kt_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] KT_IDLE  = 2'd0;
    localparam logic [1:0] KT_RUN   = 2'd1;
    localparam logic [1:0] KT_PAUSE = 2'd2;
    localparam logic [1:0] KT_ALARM = 2'd3;

    localparam logic [15:0] KT_MOD_MMSS = 16'hAA6A;

    function automatic logic [DIGIT_W-1:0] kt_clamp(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] m
    );
        return (d >= m) ? m - 4'd1 : d;
    endfunction

endpackage

// File: rtl/kt_digit.sv
// One modulus-MOD down-counting digit with borrow in/out.
// Loads clamp to MOD-1; a borrowing zero wraps to MOD-1.
module kt_digit
    import kt_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MOD = 4'd10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DIGIT_W-1:0] din,
    input  logic               bin,
    output logic [DIGIT_W-1:0] q,
    output logic               bout
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= kt_clamp(din, MOD);
        end else if (bin) begin
            q <= (q == '0) ? MOD - 4'd1 : q - 4'd1;
        end
    end

    assign bout = bin && (q == '0);

endmodule

// File: rtl/kt_countdown.sv
// N-digit mixed-radix countdown timer with run-control FSM.
// Digits are chained by a combinational borrow; the FSM owns load/dec.
module kt_countdown
    import kt_pkg::*;
#(
    parameter int                NDIG = 4,
    parameter logic [4*NDIG-1:0] MOD  = KT_MOD_MMSS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              load,
    input  logic [4*NDIG-1:0] preset,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    output logic [4*NDIG-1:0] q,
    output logic              running,
    output logic              done,
    output logic              alarm,
    output logic [1:0]        state
);

    logic [NDIG:0]     b;
    logic [4*NDIG-1:0] din;
    logic              ld;
    logic              qz;
    logic              qone;
    logic [1:0]        ns;
    logic              done_n;

    assign qz   = (q == '0);
    assign qone = (q == {{(4*NDIG-1){1'b0}}, 1'b1});

    // Clear reuses the load path with a zero operand.
    assign ld  = clear || (load && state != KT_RUN);
    assign din = clear ? '0 : preset;

    // Never decrement at zero, so the full count cannot wrap.
    assign b[0] = (state == KT_RUN) && tick && !stop && !clear && !qz;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        kt_digit #(
            .MOD(MOD[i*DIGIT_W +: DIGIT_W])
        ) u_dig (
            .clk  (clk),
            .reset(reset),
            .load (ld),
            .din  (din[i*DIGIT_W +: DIGIT_W]),
            .bin  (b[i]),
            .q    (q[i*DIGIT_W +: DIGIT_W]),
            .bout (b[i+1])
        );
    end

    always_comb begin
        ns     = state;
        done_n = 1'b0;
        if (clear) begin
            ns = KT_IDLE;
        end else begin
            case (state)
                KT_IDLE, KT_PAUSE: begin
                    if (!load && start && !qz) ns = KT_RUN;
                end
                KT_RUN: begin
                    if (stop) begin
                        ns = KT_PAUSE;
                    end else if (tick && (qone || b[NDIG])) begin
                        ns     = KT_ALARM;
                        done_n = 1'b1;
                    end
                end
                default: begin
                    if (load || start) ns = KT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= KT_IDLE;
            done  <= 1'b0;
        end else begin
            state <= ns;
            done  <= done_n;
        end
    end

    assign running = (state == KT_RUN);
    assign alarm   = (state == KT_ALARM);

endmodule
